// File: rtl/spqm_pkg.sv
// Shared constants for the strict-priority queue manager: default geometry,
// the full-depth expression and the drop counter width.
package spqm_pkg;

    localparam int N_DEF      = 3;
    localparam int W_DEF      = 8;
    localparam int DROP_CNT_W = 16;

    // One slot is sacrificed so that an n-bit count can express both empty and full.
    function automatic int max_depth(input int aw);
        return (1 << aw) - 1;
    endfunction

endpackage

// File: rtl/pkt_mem.sv
// Packet storage array: 2**n x W register file with one synchronous write port
// and one synchronous read port whose output register holds between reads.
module pkt_mem
    import spqm_pkg::*;
#(
    parameter int n = N_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [n-1:0] waddr,
    input  logic [W-1:0] wdata,
    input  logic         re,
    input  logic [n-1:0] raddr,
    output logic [W-1:0] rdata
);

    localparam int DEPTH = 1 << n;

    logic [W-1:0] mem [DEPTH];

    // The array itself is never reset; its contents are meaningless after reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pkt_queue.sv
// Single-priority packet queue: circular buffer with registered occupancy count,
// drop pulse on full pushes, and optional saturating drop counter (PKT_QUEUE_DROP_CNT_EN).
module pkt_queue
    import spqm_pkg::*;
#(
    parameter int n = N_DEF,
    parameter int W = W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [W-1:0]          wr_data,
    input  logic                  rd_en,
    output logic [W-1:0]          rd_data,
    output logic                  rd_valid,
    output logic [n-1:0]          pcount,
    output logic                  drop
`ifdef PKT_QUEUE_DROP_CNT_EN
    ,
    input  logic                  drop_clr,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    localparam logic [n-1:0] MAX = n'(max_depth(n));

    logic [n-1:0] wptr;
    logic [n-1:0] rptr;
    logic         full;
    logic         empty;
    logic         push_ok;
    logic         pop_ok;

    assign full    = (pcount == MAX);
    assign empty   = (pcount == '0);
    // Acceptance uses the registered count only, so a pop never frees room for a same-cycle push.
    assign push_ok = wr_en && !full;
    assign pop_ok  = rd_en && !empty;

    pkt_mem #(.n(n), .W(W)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push_ok),
        .waddr (wptr),
        .wdata (wr_data),
        .re    (pop_ok),
        .raddr (rptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            pcount   <= '0;
            rd_valid <= 1'b0;
            drop     <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   pcount <= pcount + 1'b1;
                2'b01:   pcount <= pcount - 1'b1;
                default: pcount <= pcount;
            endcase
            rd_valid <= pop_ok;
            drop     <= wr_en && full;
        end
    end

`ifdef PKT_QUEUE_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (drop_clr) begin
            drop_cnt <= '0;
        end else if (wr_en && full && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pkt_queue.sv
// Self-checking bench for pkt_queue: a reference FIFO predicts acceptance and
// pushes expected read data into a scoreboard that is popped on each read.
module tb_pkt_queue;

    localparam int N   = 3;
    localparam int WD  = 8;
    localparam int MAX = 7;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [WD-1:0] wr_data;
    logic          rd_en;
    logic [WD-1:0] rd_data;
    logic          rd_valid;
    logic [N-1:0]  pcount;
    logic          drop;
`ifdef PKT_QUEUE_DROP_CNT_EN
    logic          drop_clr;
    logic [15:0]   drop_cnt;
`endif

    int n_checks;
    int n_errors;
    int mcount;
    logic [WD-1:0] mq[$];
    logic [WD-1:0] sb[$];

    pkt_queue #(.n(N), .W(WD)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .pcount   (pcount),
        .drop     (drop)
`ifdef PKT_QUEUE_DROP_CNT_EN
        ,
        .drop_clr (drop_clr),
        .drop_cnt (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; the model predicts, then outputs are checked #1 after the edge.
    task automatic cyc(input logic w, input logic [WD-1:0] d, input logic r);
        logic e_drop;
        logic e_valid;
        logic push_ok;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        push_ok = w && (mcount != MAX);
        e_drop  = w && (mcount == MAX);
        e_valid = r && (mcount != 0);
        if (e_valid) sb.push_back(mq.pop_front());
        if (push_ok) mq.push_back(d);
        mcount = mq.size();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("pcount", 32'(pcount), 32'(mcount));
        chk("drop", 32'(drop), 32'(e_drop));
        chk("rd_valid", 32'(rd_valid), 32'(e_valid));
        if (e_valid) chk("rd_data", 32'(rd_data), 32'(sb.pop_front()));
    endtask

    task automatic model_reset();
        mq.delete();
        sb.delete();
        mcount = 0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        mcount   = 0;
        wr_en    = 1'b0;
        wr_data  = '0;
        rd_en    = 1'b0;
        rst      = 1'b1;
`ifdef PKT_QUEUE_DROP_CNT_EN
        drop_clr = 1'b0;
`endif
        #2 rst = 1'b0;
        #3;
        chk("rst_pcount", 32'(pcount), 0);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_drop", 32'(drop), 0);
        chk("rst_data", 32'(rd_data), 0);
        #7 rst = 1'b1;

        // Reset mid-operation
        for (int i = 0; i < 3; i++) cyc(1'b1, WD'(8'hA0 + i), 1'b0);
        cyc(1'b0, '0, 1'b1);
        rst = 1'b0;
        #2;
        chk("mid_rst_pcount", 32'(pcount), 0);
        chk("mid_rst_valid", 32'(rd_valid), 0);
        chk("mid_rst_drop", 32'(drop), 0);
        chk("mid_rst_data", 32'(rd_data), 0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        cyc(1'b0, '0, 1'b1);

        // Fill and overflow
        for (int i = 0; i < 8; i++) cyc(1'b1, WD'(8'h10 + i), 1'b0);
        chk("full_pcount", 32'(pcount), MAX);

        // Drain order and underflow
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);
        chk("empty_pcount", 32'(pcount), 0);

        // Simultaneous push and pop at empty, full and mid occupancy
        cyc(1'b1, 8'h40, 1'b1);
        chk("sim_empty", 32'(pcount), 1);
        for (int i = 1; i < 7; i++) cyc(1'b1, WD'(8'h40 + i), 1'b0);
        cyc(1'b1, 8'h4F, 1'b1);
        chk("sim_full", 32'(pcount), 6);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
        cyc(1'b1, 8'h50, 1'b1);
        chk("sim_mid", 32'(pcount), 3);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
        chk("sim_drain", 32'(pcount), 0);

        // Pointer wrap with alternating push/pop
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, WD'(8'h60 + i), 1'b0);
            chk("wrap_le1", 32'(pcount <= 1), 1);
            cyc(1'b0, '0, 1'b1);
        end
        chk("wrap_sb_empty", 32'(sb.size()), 0);

`ifdef PKT_QUEUE_DROP_CNT_EN
        for (int i = 0; i < 7; i++) cyc(1'b1, WD'(8'h80 + i), 1'b0);
        drop_clr = 1'b1;
        cyc(1'b0, '0, 1'b0);
        drop_clr = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'hEE, 1'b0);
        chk("drop_cnt", 32'(drop_cnt), 5);
        drop_clr = 1'b1;
        cyc(1'b1, 8'hEF, 1'b0);
        drop_clr = 1'b0;
        chk("drop_cnt_clr", 32'(drop_cnt), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
